data_ram: RTL

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram_pkg.sv | 51 +++++
 rtl/data_ram_load_ext.sv | 28 ++
 rtl/data_ram.sv | 130 +++++++++++++
 3 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and helpers for data_ram: RV32 load/store size encodings,
// controller states and the offset/lane/alignment helpers used on the request path.
package data_ram_pkg;

  typedef enum logic [2:0] {
    MS_B  = 3'b000,
    MS_H  = 3'b001,
    MS_W  = 3'b010,
    MS_BU = 3'b100,
    MS_HU = 3'b101
  } mem_size_e;

  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_RUN   = 1'b1
  } ram_state_e;

  function automatic logic size_legal(input logic [2:0] funct3);
    case (funct3)
      MS_B, MS_H, MS_W, MS_BU, MS_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Offset forced to the natural boundary of the access size.
  function automatic logic [1:0] align_offset(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      MS_H, MS_HU: return {addr_lo[1], 1'b0};
      MS_W:        return 2'b00;
      default:     return addr_lo;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      MS_H, MS_HU: return addr_lo[0];
      MS_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      MS_B, MS_BU: return 4'b0001 << offset;
      MS_H, MS_HU: return 4'b0011 << offset;
      MS_W:        return 4'b1111;
      default:     return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_load_ext.sv
// Combinational load formatter: picks the byte/half at the registered offset and
// sign- or zero-extends it; reserved sizes yield zero.
module data_ram_load_ext
  import data_ram_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      MS_B:    data = {{24{byte_sel[7]}}, byte_sel};
      MS_BU:   data = {24'h0, byte_sel};
      MS_H:    data = {{16{half_sel[15]}}, half_sel};
      MS_HU:   data = {16'h0, half_sel};
      MS_W:    data = word;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_ram.sv
// Byte-lane-enabled data RAM with one-cycle loads and optional zero-fill after reset.
// Define DATA_RAM_MISALIGN_EN to trap misaligned accesses (no write, zero load, oMisalign pulse).
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDRWIDTH      = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iReq,
  input  logic                 iWR,
  input  logic [2:0]           iFunct3,
  input  logic [ADDRWIDTH-1:0] iAddress,
  input  logic [31:0]          iWriteData,
  output logic                 oReady,
  output logic                 oReadValid,
  output logic [31:0]          oReadData
`ifdef DATA_RAM_MISALIGN_EN
  ,
  output logic                 oMisalign
`endif
);

  localparam int WAW   = ADDRWIDTH - 2;
  localparam int DEPTH = 1 << WAW;

  ram_state_e       state_q, state_d;
  logic [WAW-1:0]   clr_cnt_q;
  logic [3:0][7:0]  mem [DEPTH];
  logic [WAW-1:0]   rd_addr_q;
  logic [WAW-1:0]   word_addr;
  logic [1:0]       offset, offset_q;
  logic [2:0]       size_q;
  logic             rd_vld_q, mis_q;
  logic             accept, misaligned, store_en, load_en, clear_en;
  logic [3:0]       lane_en;
  logic [31:0]      lane_dat;
  logic [31:0]      ext_data;

  // Gating with the reset pin keeps oReady low during reset even when the
  // reset state is RUN (CLEAR_ON_RESET=0).
  assign oReady    = (state_q == RAM_RUN) && iRst_n;
  assign accept    = iReq && oReady;
  assign word_addr = iAddress[ADDRWIDTH-1:2];
  assign offset    = align_offset(iFunct3, iAddress[1:0]);
`ifdef DATA_RAM_MISALIGN_EN
  assign misaligned = is_misaligned(iFunct3, iAddress[1:0]);
`else
  assign misaligned = 1'b0;
`endif
  assign store_en = accept && iWR && size_legal(iFunct3) && !misaligned;
  assign load_en  = accept && !iWR;
  assign clear_en = (state_q == RAM_CLEAR);
  assign lane_en  = lane_mask(iFunct3, offset);

  always_comb begin
    case (iFunct3)
      MS_B, MS_BU: lane_dat = {4{iWriteData[7:0]}};
      MS_H, MS_HU: lane_dat = {2{iWriteData[15:0]}};
      default:     lane_dat = iWriteData;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RAM_CLEAR: if (clr_cnt_q == '1) state_d = RAM_RUN;
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      clr_cnt_q <= '0;
    end else if (clear_en) begin
      clr_cnt_q <= clr_cnt_q + WAW'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rd_vld_q <= 1'b0;
      mis_q    <= 1'b0;
      offset_q <= 2'b00;
      size_q   <= 3'b000;
    end else begin
      rd_vld_q <= load_en;
      mis_q    <= accept && misaligned;
      if (load_en) begin
        offset_q <= offset;
        size_q   <= iFunct3;
      end
    end
  end

  // Storage stays reset-free so it maps onto block RAM with a registered read address.
  always_ff @(posedge iClk) begin
    if (clear_en) begin
      mem[clr_cnt_q] <= '0;
    end else if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_addr][i] <= lane_dat[i*8 +: 8];
      end
    end
    if (load_en) rd_addr_q <= word_addr;
  end

  data_ram_load_ext u_load_ext (
    .word   (mem[rd_addr_q]),
    .funct3 (size_q),
    .offset (offset_q),
    .data   (ext_data)
  );

  assign oReadValid = rd_vld_q;
  assign oReadData  = (rd_vld_q && !mis_q) ? ext_data : 32'h0;
`ifdef DATA_RAM_MISALIGN_EN
  assign oMisalign  = mis_q;
`endif

endmodule
